// File: rtl/hpdl_write_scheduler.sv
// hpdl_write_scheduler: owns the shared HPDL-1414 bus, arbitrates host
// and refresh writes and times each setup / strobe / hold bus cycle.
`timescale 1ns/1ps
module hpdl_write_scheduler #(
    parameter int SETUP_CYC   = 2,
    parameter int WR_CYC      = 3,
    parameter int HOLD_CYC    = 1,
    parameter int REFRESH_DIV = 4096,
    parameter bit ADDR_INVERT = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req0_valid,
    input  logic [3:0] i_req0_pos,
    input  logic [7:0] i_req0_char,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [3:0] i_req1_pos,
    input  logic [7:0] i_req1_char,
    output logic       o_req1_ready,
    output logic [3:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic [6:0] o_hpdl_data,
    output logic [1:0] o_hpdl_addr,
    output logic [3:0] o_hpdl_wr_n,
    output logic       o_busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam int DIV_W = $clog2(REFRESH_DIV);

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WR_LOAD    = 4'(WR_CYC - 1);
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [2:0]       state;
    logic [3:0]       phase_cnt;
    logic [DIV_W-1:0] divider;
    logic             refresh_tick;
    logic             refresh_pend;
    logic [3:0]       scan_pos;
    logic [1:0]       display;
    logic             is_refresh;
    logic             idle;
    logic             host_grant;
    logic             refresh_grant;
    logic [3:0]       grant_pos;
    logic [6:0]       grant_code;
    logic             unused_bits;

    function automatic logic [6:0] filter_char(input logic [6:0] code);
        if (code >= 7'h20 && code <= 7'h5F) begin
            return code;
        end
        return 7'h20;
    endfunction

    function automatic logic [1:0] encode_digit(input logic [1:0] digit);
        return ADDR_INVERT ? ~digit : digit;
    endfunction

    function automatic logic [3:0] strobe_mask(input logic [1:0] disp);
        return ~(4'b0001 << disp);
    endfunction

    // Bit 7 of every character source is deliberately ignored.
    assign unused_bits = ^{i_req0_char[7], i_req1_char[7], i_rd_data[7]};

    assign idle          = (state == ST_IDLE);
    assign o_busy        = !idle;
    assign o_req0_ready  = idle && i_rst_n;
    assign o_req1_ready  = idle && i_rst_n && !i_req0_valid;
    assign o_rd_addr     = scan_pos;

    assign host_grant    = idle && (i_req0_valid || i_req1_valid);
    assign refresh_grant = idle && !i_req0_valid && !i_req1_valid
                           && refresh_pend;

    assign grant_pos  = i_req0_valid ? i_req0_pos : i_req1_pos;
    assign grant_code = i_req0_valid ? i_req0_char[6:0]
                                     : i_req1_char[6:0];

    assign refresh_tick = (divider == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            divider      <= '0;
            refresh_pend <= 1'b0;
        end else begin
            divider <= refresh_tick ? '0 : divider + DIV_W'(1);
            // A tick landing while a refresh is already pending is lost.
            if (state == ST_FETCH) begin
                refresh_pend <= 1'b0;
            end else if (refresh_tick) begin
                refresh_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            phase_cnt   <= 4'd0;
            scan_pos    <= 4'd0;
            display     <= 2'd0;
            is_refresh  <= 1'b0;
            o_hpdl_data <= 7'h20;
            o_hpdl_addr <= encode_digit(2'd0);
            o_hpdl_wr_n <= 4'hF;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (host_grant) begin
                        state       <= ST_SETUP;
                        phase_cnt   <= SETUP_LOAD;
                        display     <= grant_pos[3:2];
                        is_refresh  <= 1'b0;
                        o_hpdl_data <= filter_char(grant_code);
                        o_hpdl_addr <= encode_digit(grant_pos[1:0]);
                    end else if (refresh_grant) begin
                        state      <= ST_FETCH;
                        display    <= scan_pos[3:2];
                        is_refresh <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state       <= ST_SETUP;
                    phase_cnt   <= SETUP_LOAD;
                    o_hpdl_data <= filter_char(i_rd_data[6:0]);
                    o_hpdl_addr <= encode_digit(scan_pos[1:0]);
                end
                ST_SETUP: begin
                    if (phase_cnt == 4'd0) begin
                        state       <= ST_STROBE;
                        phase_cnt   <= WR_LOAD;
                        o_hpdl_wr_n <= strobe_mask(display);
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (phase_cnt == 4'd0) begin
                        state       <= ST_HOLD;
                        phase_cnt   <= HOLD_LOAD;
                        o_hpdl_wr_n <= 4'hF;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (phase_cnt == 4'd0) begin
                        state <= ST_IDLE;
                        if (is_refresh) begin
                            scan_pos <= scan_pos + 4'd1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    o_hpdl_wr_n <= 4'hF;
                end
            endcase
        end
    end

    wr_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $countones(~o_hpdl_wr_n) <= 1);

    wr_only_in_strobe: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (state == ST_STROBE) || (o_hpdl_wr_n == 4'hF));

endmodule

// File: tb/tb_hpdl_write_scheduler.sv
// Bench for hpdl_write_scheduler: a transaction-timeline model predicts
// every bus cycle, ready and refresh-scan step of random host traffic.
`timescale 1ns/1ps
module tb_hpdl_write_scheduler;

    localparam int S   = 2;
    localparam int W   = 3;
    localparam int H   = 1;
    localparam int DIV = 16;
    localparam int LEN = S + W + H;

    typedef struct {
        logic [3:0] p;
        logic [7:0] c;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rst1_n = 1'b1;
    always #5 clk = ~clk;

    logic       v0 = 0, v1 = 0;
    logic [3:0] p0 = 0, p1 = 0;
    logic [7:0] c0 = 0, c1 = 0;
    logic       rdy0, rdy1, busy;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic [6:0] hdata;
    logic [1:0] haddr;
    logic [3:0] wr_n;
    logic [7:0] mem [16];

    always @(posedge clk) rd_data <= mem[rd_addr];

    logic       f_valid = 0;
    logic [3:0] f_pos = 0;
    logic [7:0] f_char = 0;
    logic       f_rdy0, f_rdy1, f_busy;
    logic [3:0] f_rd_addr;
    logic [6:0] f_hdata;
    logic [1:0] f_haddr;
    logic [3:0] f_wr_n;
    bit         done1 = 0;

    hpdl_write_scheduler #(
        .SETUP_CYC(S), .WR_CYC(W), .HOLD_CYC(H),
        .REFRESH_DIV(DIV), .ADDR_INVERT(1'b1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(v0), .i_req0_pos(p0), .i_req0_char(c0),
        .o_req0_ready(rdy0),
        .i_req1_valid(v1), .i_req1_pos(p1), .i_req1_char(c1),
        .o_req1_ready(rdy1),
        .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_hpdl_data(hdata), .o_hpdl_addr(haddr),
        .o_hpdl_wr_n(wr_n), .o_busy(busy)
    );

    hpdl_write_scheduler #(
        .SETUP_CYC(1), .WR_CYC(1), .HOLD_CYC(1),
        .REFRESH_DIV(4096), .ADDR_INVERT(1'b1)
    ) dut_fast (
        .i_clk(clk), .i_rst_n(rst1_n),
        .i_req0_valid(f_valid), .i_req0_pos(f_pos), .i_req0_char(f_char),
        .o_req0_ready(f_rdy0),
        .i_req1_valid(1'b0), .i_req1_pos(4'h0), .i_req1_char(8'h00),
        .o_req1_ready(f_rdy1),
        .o_rd_addr(f_rd_addr), .i_rd_data(8'h00),
        .o_hpdl_data(f_hdata), .o_hpdl_addr(f_haddr),
        .o_hpdl_wr_n(f_wr_n), .o_busy(f_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] blank_filter(input logic [7:0] ch);
        int code;
        code = ch % 128;
        return (code >= 32 && code < 96) ? 7'(code) : 7'd32;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] pos);
        return 2'(3 - pos % 4);
    endfunction

    // Model: one "current write" with its grant edge and bus start edge.
    int         k, last_e, idle_at, scan;
    bit         pend, have_w, w_ref, acc0, acc1;
    int         w_g, w_base;
    logic [1:0] w_disp, w_addr, prev_addr;
    logic [6:0] w_data, prev_data;
    int         gap_pct;
    req_t       q0[$], q1[$];

    task automatic model_reset();
        k = 0; last_e = -1; idle_at = 0; scan = 0;
        pend = 0; have_w = 0; w_ref = 0; acc0 = 0; acc1 = 0;
        w_g = 0; w_base = 0;
        prev_data = 7'h20; prev_addr = 2'b11;
        v0 = 0; v1 = 0;
        q0.delete(); q1.delete();
    endtask

    task automatic model_edge();
        int   e;
        bit   ref_g;
        req_t r;
        e = k;
        ref_g = 0;
        acc0 = 0;
        acc1 = 0;
        if (have_w && w_ref && e == w_base + LEN) scan = (scan + 1) % 16;
        if (e >= idle_at) begin
            if (v0) begin
                r.p = p0; r.c = c0; acc0 = 1;
            end else if (v1) begin
                r.p = p1; r.c = c1; acc1 = 1;
            end else if (pend) begin
                r.p = 4'(scan); r.c = mem[scan]; ref_g = 1;
            end
            if (acc0 || acc1 || ref_g) begin
                prev_data = have_w ? w_data : 7'h20;
                prev_addr = have_w ? w_addr : 2'b11;
                have_w  = 1;
                w_g     = e;
                w_base  = e + (ref_g ? 1 : 0);
                w_ref   = ref_g;
                w_disp  = r.p[3:2];
                w_addr  = enc(r.p);
                w_data  = blank_filter(r.c);
                idle_at = w_base + LEN + 1;
            end
        end
        if (e % DIV == DIV - 1) pend = 1;
        if (have_w && w_ref && e == w_g + 1) pend = 0;
        last_e = e;
        k++;
    endtask

    task automatic check_cycle();
        int         e;
        bit         bz, st;
        logic [3:0] exp_wr;
        e  = last_e;
        bz = have_w && e >= w_g && e < w_base + LEN;
        st = have_w && e >= w_base + S && e < w_base + S + W;
        exp_wr = st ? ~(4'b0001 << w_disp) : 4'hF;
        check("busy", busy, bz);
        check("ready0", rdy0, !bz);
        check("ready1", rdy1, !bz && !v0);
        check("wr_n", wr_n, exp_wr);
        check("data", hdata, (have_w && e >= w_base) ? w_data : prev_data);
        check("addr", haddr, (have_w && e >= w_base) ? w_addr : prev_addr);
        check("rd_addr", rd_addr, scan);
        check("wr_onehot", $countones(~wr_n) <= 1, 1);
    endtask

    task automatic drive();
        req_t r;
        if (acc0) v0 = 0;
        if (acc1) v1 = 0;
        acc0 = 0;
        acc1 = 0;
        if (!v0) begin
            p0 = 4'($urandom); c0 = 8'($urandom);
            if (q0.size() > 0 && $urandom_range(99) >= gap_pct) begin
                r = q0.pop_front(); v0 = 1; p0 = r.p; c0 = r.c;
            end
        end
        if (!v1) begin
            p1 = 4'($urandom); c1 = 8'($urandom);
            if (q1.size() > 0 && $urandom_range(99) >= gap_pct) begin
                r = q1.pop_front(); v1 = 1; p1 = r.p; c1 = r.c;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_cycle();
            drive();
        end
    endtask

    task automatic push_random(input int n);
        req_t r;
        for (int i = 0; i < n; i++) begin
            r.p = 4'($urandom); r.c = 8'($urandom); q0.push_back(r);
            r.p = 4'($urandom); r.c = 8'($urandom); q1.push_back(r);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // S=W=H=1 instance under continuous req0: one grant every 4 cycles.
    initial begin
        logic [3:0] cp, m;
        logic [7:0] cc;
        cp = 0; cc = 0;
        #1 rst1_n = 0;
        repeat (3) @(negedge clk);
        rst1_n = 1;
        f_valid = 1; f_pos = 4'($urandom); f_char = 8'($urandom);
        for (int e = 0; e < 48; e++) begin
            @(posedge clk);
            if (e % 4 == 0) begin
                cp = f_pos; cc = f_char;
            end
            @(negedge clk);
            m = (e % 4 == 1) ? ~(4'b0001 << cp[3:2]) : 4'hF;
            check("fast_wr_n", f_wr_n, m);
            check("fast_ready0", f_rdy0, e % 4 == 3);
            check("fast_busy", f_busy, e % 4 != 3);
            check("fast_onehot", $countones(~f_wr_n) <= 1, 1);
            if (e % 4 == 1) begin
                check("fast_data", f_hdata, blank_filter(cc));
                check("fast_addr", f_haddr, enc(cp));
            end
            if (e % 4 == 0) begin
                f_pos = 4'($urandom); f_char = 8'($urandom);
            end
        end
        done1 = 1;
    end

    initial begin
        string s;
        int    n;
        s = "HELLO, hpdl 1414";
        for (int i = 0; i < 16; i++) mem[i] = s[i];
        model_reset();
        gap_pct = 0;
        #1 rst_n = 0;
        @(negedge clk);
        check("rst_wr_n", wr_n, 4'hF);
        check("rst_data", hdata, 7'h20);
        check("rst_addr", haddr, 2'b11);
        check("rst_rd_addr", rd_addr, 4'd0);
        check("rst_ready0", rdy0, 1'b0);
        check("rst_ready1", rdy1, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1;

        q0.push_back('{4'd5, 8'h41});
        run(10);
        q0.push_back('{4'd0, 8'h41});
        q1.push_back('{4'd15, 8'h5A});
        run(20);
        q0.push_back('{4'd3, 8'h61});
        q0.push_back('{4'd7, 8'h1F});
        q0.push_back('{4'd12, 8'hC1});
        run(30);

        run(300);

        for (int i = 0; i < 60; i++) q0.push_back('{4'($urandom), 8'($urandom)});
        run(430);
        run(40);

        gap_pct = 50;
        push_random(150);
        run(3000);

        q0.delete(); q1.delete();
        gap_pct = 0;
        q0.push_back('{4'd9, 8'h42});
        n = 0;
        while (wr_n == 4'hF && n < 60) begin
            run(1);
            n++;
        end
        check("strobe_seen", wr_n != 4'hF, 1'b1);
        #2 rst_n = 0;
        #1;
        check("abort_wr_n", wr_n, 4'hF);
        check("abort_busy", busy, 1'b0);
        check("abort_ready0", rdy0, 1'b0);
        check("abort_data", hdata, 7'h20);
        check("abort_addr", haddr, 2'b11);
        check("abort_rd_addr", rd_addr, 4'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1;
        run(40);

        n = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fast_done", done1, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
